// File: rtl/perceptron_pkg.sv
// perceptron_pkg: scheduler state encoding and datapath widths shared with the mult array and activation.
package perceptron_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_BIAS  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam int PKG_PSUM_W = 22;
    localparam int PKG_ACC_W  = 25;
    localparam logic signed [PKG_ACC_W-1:0] PKG_BIAS = 25'sd2048;
endpackage

// File: rtl/perceptron_sched_mac_valid_pipe.sv
// mac_valid_pipe: tracks which cycles carry a real psum from the ROM + mult array.
module mac_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] pipe_q, pipe_d;

    always_comb pipe_d = flush ? '0 : DEPTH'({pipe_q, din});

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/perceptron_sched.sv
// perceptron_sched: walks an image's ROM rows through the shared mult array and returns biased sum + class.
// Optional abort input enabled by PERCEPTRON_SCHED_ABORT_EN.
module perceptron_sched import perceptron_pkg::*; #(
    parameter int NUM_CHUNKS = 4,
    parameter int CHUNK_W    = 2,
    parameter int IMG_W      = 6,
    parameter int PSUM_W     = PKG_PSUM_W,
    parameter int ACC_W      = PKG_ACC_W,
    parameter int MAC_LAT    = 2,
    parameter logic signed [ACC_W-1:0] BIAS = PKG_BIAS
) (
    input  logic                       clk_12MHz,
    input  logic                       rst_n,
`ifdef PERCEPTRON_SCHED_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [IMG_W-1:0]           req_image,
    output logic                       rom_en,
    output logic [IMG_W+CHUNK_W-1:0]   rom_addr,
    output logic                       mult_rst,
    input  logic signed [PSUM_W-1:0]   psum,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [ACC_W-1:0]    res_acc,
    output logic                       res_class
);
    generate
        if (ACC_W != PSUM_W + CHUNK_W + 1 || (1 << CHUNK_W) != NUM_CHUNKS || MAC_LAT > NUM_CHUNKS) begin : g_bad_cfg
            $error("perceptron_sched: inconsistent ACC_W/CHUNK_W/NUM_CHUNKS/MAC_LAT");
        end
    endgenerate

    logic [2:0]               state_q, state_d;
    logic [IMG_W-1:0]         img_q, img_d;
    logic [CHUNK_W-1:0]       chunk_q, chunk_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, res_acc_q, res_acc_d, biased;
    logic                     res_class_q, res_class_d;
    logic                     abort_w, pipe_out;

`ifdef PERCEPTRON_SCHED_ABORT_EN
    assign abort_w = abort && state_q != S_IDLE;
`else
    assign abort_w = 1'b0;
`endif

    assign biased = acc_q + BIAS;

    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        chunk_d     = chunk_q;
        acc_d       = pipe_out ? acc_q + {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum} : acc_q;
        res_acc_d   = res_acc_q;
        res_class_d = res_class_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                img_d   = req_image;
                acc_d   = '0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                chunk_d = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                chunk_d = chunk_q + 1'b1;
                if (chunk_q == CHUNK_W'(NUM_CHUNKS-1)) state_d = S_DRAIN;
            end
            // chunk wraps to 0 on leaving ISSUE, so it doubles as the drain counter
            S_DRAIN: begin
                chunk_d = chunk_q + 1'b1;
                if (chunk_q == CHUNK_W'(MAC_LAT-1)) state_d = S_BIAS;
            end
            S_BIAS: begin
                acc_d       = biased;
                res_acc_d   = biased;
                res_class_d = !biased[ACC_W-1] && biased != '0;
                state_d     = S_DONE;
            end
            S_DONE: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_w) state_d = S_IDLE;
    end

    always_ff @(posedge clk_12MHz or negedge rst_n)
        if (!rst_n) begin
            state_q     <= S_IDLE;
            img_q       <= '0;
            chunk_q     <= '0;
            acc_q       <= '0;
            res_acc_q   <= '0;
            res_class_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            chunk_q     <= chunk_d;
            acc_q       <= acc_d;
            res_acc_q   <= res_acc_d;
            res_class_q <= res_class_d;
        end

    mac_valid_pipe #(.DEPTH(MAC_LAT)) u_pipe (
        .clk   (clk_12MHz),
        .rst_n (rst_n),
        .flush (abort_w),
        .din   (rom_en),
        .dout  (pipe_out)
    );

    assign req_ready = state_q == S_IDLE;
    assign rom_en    = state_q == S_ISSUE && !abort_w;
    assign rom_addr  = rom_en ? {img_q, chunk_q} : '0;
    assign mult_rst  = state_q == S_CLEAR;
    assign res_valid = state_q == S_DONE;
    assign res_acc   = res_acc_q;
    assign res_class = res_class_q;
endmodule

// File: tb/tb_perceptron_sched.sv
// tb_perceptron_sched: directed vectors against a ROM + mult stub with hand-computed sums.
module tb_perceptron_sched;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               abort = 1'b0;
    logic               req_valid = 1'b0, req_ready;
    logic [5:0]         req_image = '0;
    logic               rom_en, mult_rst, res_valid, res_class;
    logic [7:0]         rom_addr;
    logic signed [21:0] psum;
    logic               res_ready = 1'b0;
    logic signed [24:0] res_acc;
    int                 n_vec = 0, n_bad = 0;
    int                 psum_tab [4];
    logic               v1 = 1'b0, v2 = 1'b0;
    logic [1:0]         a1 = '0, a2 = '0;

    always #5 clk = ~clk;

    perceptron_sched dut (
        .clk_12MHz (clk),
        .rst_n     (rst_n),
`ifdef PERCEPTRON_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_image (req_image),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .mult_rst  (mult_rst),
        .psum      (psum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_acc   (res_acc),
        .res_class (res_class)
    );

    // ROM register then mult register; garbage on invalid cycles must be ignored
    always @(posedge clk) begin
        v1 <= rom_en;
        a1 <= rom_addr[1:0];
        v2 <= v1;
        a2 <= a1;
    end
    assign psum = v2 ? 22'(psum_tab[a2]) : 22'sh15A5A;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [5:0] img, input int p0, input int p1, input int p2,
                          input int p3, input int exp_acc, input int hold);
        psum_tab[0] = p0; psum_tab[1] = p1; psum_tab[2] = p2; psum_tab[3] = p3;
        req_valid = 1'b1;
        req_image = img;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        chk("res_valid_idle", res_valid, 0);
        tick;
        req_image = ~img;
        @(negedge clk);
        chk("mult_rst", mult_rst, 1);
        chk("rom_en_clear", rom_en, 0);
        chk("req_ready_busy", req_ready, 0);
        for (int c = 0; c < 4; c++) begin
            tick;
            @(negedge clk);
            chk("rom_en_issue", rom_en, 1);
            chk("rom_addr", rom_addr, {img, 2'(c)});
            chk("mult_rst_issue", mult_rst, 0);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            @(negedge clk);
            chk("rom_en_drain", rom_en, 0);
            chk("res_valid_early", res_valid, 0);
        end
        for (int k = 0; k <= hold; k++) begin
            tick;
            res_ready = (k == hold);
            @(negedge clk);
            chk("res_valid", res_valid, 1);
            chk("res_acc", res_acc, exp_acc);
            chk("res_class", res_class, exp_acc > 0 ? 1 : 0);
            chk("req_ready_done", req_ready, 0);
            chk("rom_en_done", rom_en, 0);
        end
        tick;
        req_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_mult_rst", mult_rst, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_acc", res_acc, 0);
        chk("rst_res_class", res_class, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        do_req(6'h2A, 100, -50, 200, -10, 2288, 0);
        do_req(6'h01, -2048, 0, 0, 0, 0, 0);
        do_req(6'h02, -3000, 0, 0, 0, -952, 0);
        do_req(6'h3F, 2097151, 2097151, 2097151, 2097151, 8390652, 0);
        do_req(6'h00, -2097152, -2097152, -2097152, -2097152, -8386560, 0);
        do_req(6'h3F, 1, 2, 3, 4, 2058, 5);
        @(negedge clk);
        chk("post_res_valid", res_valid, 0);
        chk("post_res_acc", res_acc, 2058);
        chk("post_res_class", res_class, 1);
        chk("post_req_ready", req_ready, 1);
        psum_tab[0] = 999; psum_tab[1] = 999; psum_tab[2] = 999; psum_tab[3] = 999;
        tick;
        req_valid = 1'b1;
        req_image = 6'h15;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_en", rom_en, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_mult_rst", mult_rst, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_acc", res_acc, 0);
        chk("mid_rst_res_class", res_class, 0);
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        tick;
        do_req(6'h15, 7, 7, 7, 7, 2076, 0);
`ifdef PERCEPTRON_SCHED_ABORT_EN
        psum_tab[0] = 5000; psum_tab[1] = 5000; psum_tab[2] = 5000; psum_tab[3] = 5000;
        req_valid = 1'b1;
        req_image = 6'h0C;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        tick;
        abort = 1'b1;
        #1;
        chk("abort_rom_en", rom_en, 0);
        tick;
        abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_idle", req_ready, 1);
            chk("abort_res_valid", res_valid, 0);
            tick;
        end
        do_req(6'h0C, 5, 5, 5, 5, 2068, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/perceptron_sched.md
Name: perceptron_sched

Overview:
- Controller that sequences one perceptron inference over a wider image than a single 16-multiplier pass can cover.
- For each accepted request it walks the image's NUM_CHUNKS ROM rows through the shared ROM + 16-mult array, clearing the mults first.
- It accumulates the per-chunk partial dot sums, adds the bias, and returns the signed sum plus a 1-bit class over a valid/ready handshake.
- Sits between the image-select logic and the activation/seven-segment path.

Parameters:
- NUM_CHUNKS, 4: ROM rows per image; power of two.
- CHUNK_W, 2: log2(NUM_CHUNKS).
- IMG_W, 6: image index width.
- PSUM_W, 22: width of the signed partial sum from the mult array's adder tree.
- ACC_W, 25: accumulator width; must equal PSUM_W+CHUNK_W+1, so it cannot overflow (elaboration-time check).
- MAC_LAT, 2: cycles from rom_en/rom_addr to the matching psum (1 ROM + 1 mult register).
- BIAS, 25'sd2048: signed bias added once per inference.

Ports:
- clk_12MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  inference request.
- req_ready  out  1  high only in IDLE.
- req_image  in  IMG_W  image index; sampled on accept.
- rom_en  out  1  ROM read strobe, one per chunk.
- rom_addr  out  IMG_W+CHUNK_W  read address = {image, chunk}.
- mult_rst  out  1  one-cycle clear pulse to the mult array.
- psum  in  PSUM_W  signed partial sum for the chunk issued MAC_LAT cycles earlier.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_acc  out  ACC_W  signed biased dot product.
- res_class  out  1  1 iff res_acc > 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; chunk counter, valid pipe, acc, res_acc, res_class=0.
  - rom_en, mult_rst, res_valid=0; rom_addr=0.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, BIAS, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_image, acc<=0, go CLEAR.
  - req_image changes after accept have no effect.
- CLEAR:
  - mult_rst=1 for exactly one cycle; chunk<=0; go ISSUE.
- ISSUE:
  - rom_en=1 and rom_addr={img,chunk} every cycle; chunk increments.
  - After chunk NUM_CHUNKS-1 is issued, go DRAIN.
  - ISSUE lasts exactly NUM_CHUNKS cycles.
- Valid pipe (MAC_LAT deep):
  - Each cycle with rom_en=1 shifts a 1 into the pipe.
  - When the pipe output is 1, acc <= acc + sign_extend(psum) on that edge.
  - psum is ignored whenever the pipe output is 0.
- DRAIN:
  - Stays exactly MAC_LAT cycles; the pipe is empty at exit.
- BIAS:
  - acc <= acc + BIAS; go DONE.
- DONE:
  - res_valid=1; res_acc=acc; res_class=(acc>0), so acc==0 gives class 0.
  - Outputs hold stable until res_ready.
  - On res_valid&res_ready: go IDLE, res_valid deasserts next cycle, res_acc/res_class retain their value.
- Latency:
  - Accept at cycle 0; first rom_en at cycle 2; res_valid first high at cycle 3+NUM_CHUNKS+MAC_LAT (9 with defaults).
  - Minimum request spacing: 4+NUM_CHUNKS+MAC_LAT cycles with res_ready held high.
- req_valid outside IDLE: ignored, since req_ready=0; no queuing.
- rst_n asserted mid-operation: immediate return to reset values; a partial result is never presented.

Optional Feature:
- Macro: PERCEPTRON_SCHED_ABORT_EN.
- Defined: adds input abort (1 bit).
  - In any non-IDLE state, abort=1 forces state<=IDLE and flushes the valid pipe on the next edge.
  - rom_en drops that cycle and res_valid is never asserted for the aborted request.
  - abort is ignored in IDLE.
- Undefined: no abort port; every accepted request runs to DONE.

Decomposition:
- perceptron_pkg holds:
  - state encoding localparams: IDLE=0, CLEAR=1, ISSUE=2, DRAIN=3, BIAS=4, DONE=5.
  - PSUM_W, default ACC_W, default BIAS.
  - shared with the mult array and activation.
- One sub-module: mac_valid_pipe (MAC_LAT-deep shift register with synchronous flush).
  - FSM, counter and accumulator stay in perceptron_sched.

Test Plan:
- Address sequence: req_image=6'h2A accepted at cycle 0 -> mult_rst at cycle 1; rom_addr=8'hA8,A9,AA,AB with rom_en=1 in cycles 2-5; rom_en=0 otherwise.
- Positive result: psum stub returns 100, -50, 200, -10 for chunks 0-3 -> res_valid rises at cycle 9, res_acc=2288, res_class=1.
- Zero/negative: psums -2048,0,0,0 -> res_acc=0, res_class=0; psums -3000,0,0,0 -> res_acc=-952, res_class=0.
- Backpressure: res_ready=0 for 5 cycles in DONE with req_valid=1 -> res_valid/res_acc stable, req_ready=0, no new rom_en; accept a new request only the cycle after the handshake.
- Reset mid-run: rst_n low at cycle 3 (during ISSUE) -> all outputs 0 immediately; after release req_ready=1 and the next request yields a correct, uncontaminated result.
- Abort (macro defined): abort=1 at cycle 4 -> IDLE at cycle 5, res_valid never high; the next request's res_acc excludes the aborted psums.
